// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser: FSM state encoding and truth-table
// constants for the common two-input gates (bit i = expected Q when gate_in == i).
package gate_exerciser_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0] OR2_TT   = 4'b1110;
  localparam logic [3:0] AND2_TT  = 4'b1000;
  localparam logic [3:0] XOR2_TT  = 4'b0110;
  localparam logic [3:0] NAND2_TT = 4'b0111;
  localparam logic [3:0] NOR2_TT  = 4'b0001;

  // Hold counter width; covers HOLD_CYCLES up to 255.
  localparam int unsigned HOLD_CNT_W = 8;

endpackage

// File: rtl/gate_exerciser_if.sv
// Stimulus/response bundle between a test controller and the gate exerciser.
//   start     - begin a run (controller -> exerciser)
//   gate_out  - Q of the gate under test (gate -> exerciser)
//   gate_in   - stimulus to gate inputs, bit 0 -> A, bit 1 -> B
//   busy/done/pass/err_count/fail_vec - run status and results
// master: controller / board side.  slave: the exerciser.
interface gate_exerciser_if #(
  parameter int unsigned N_IN = 2
);
  logic                 start;
  logic                 gate_out;
  logic [N_IN-1:0]      gate_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_count;
  logic [2**N_IN-1:0]   fail_vec;

  modport master (
    output start, gate_out,
    input  gate_in, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, gate_out,
    output gate_in, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_exerciser_hold_timer.sv
// Hold timer: up-counter that paces how long each input combination is held.
//   clk, rst - clock and synchronous active-high reset
//   clear    - force count to 0 (wins over enable)
//   enable   - advance count by one
//   last     - count equals HOLD_CYCLES-1
module gate_exerciser_hold_timer
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == HOLD_CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/gate_exerciser.sv
// Gate exerciser: steps gate_in through every combination, holds each for
// HOLD_CYCLES cycles, samples gate_out on the last hold cycle and compares it
// with EXPECTED. Results (err_count, fail_vec, pass) are kept until next start.
//   clk, rst - clock and synchronous active-high reset
//   bus      - slave side of gate_exerciser_if (start, gate_in/out, status)
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned       N_IN        = 2,
  parameter int unsigned       HOLD_CYCLES = 4,
  parameter logic [2**N_IN-1:0] EXPECTED   = OR2_TT
) (
  input logic              clk,
  input logic              rst,
  gate_exerciser_if.slave  bus
);

  localparam int unsigned     COMBOS   = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(COMBOS - 1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     index_q, index_d;
  logic [N_IN:0]       err_q, err_d;
  logic [COMBOS-1:0]   fail_q, fail_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                launch;
  logic                hold_last;
  logic                run_sample;
  logic                mismatch;

  // Restart the hold count on a new run and after every sampled combination.
  gate_exerciser_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (launch | run_sample),
    .enable (state_q == StRun),
    .last   (hold_last)
  );

  assign run_sample = (state_q == StRun) && hold_last;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    launch   = 1'b0;
    mismatch = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          launch  = 1'b1;
          state_d = StRun;
          index_d = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        // start is deliberately ignored here
        if (hold_last) begin
          mismatch = (bus.gate_out != EXPECTED[index_q]);
          if (mismatch) begin
            err_d           = err_q + 1'b1;
            fail_d[index_q] = 1'b1;
          end
          if (index_q == LAST_IDX) begin
            state_d = StDone;
            index_d = '0;  // gate_in returns to 0 while idle/done
            pass_d  = (err_d == '0);
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.gate_in   = index_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: two instances (2-input OR, hold 4; 3-input OR,
// hold 1). The gate under test is modelled as a lookup table resp[gate_in].
// Expected results come from the table: a combination fails when its response
// differs from the truth table, the error count is the number of such bits.
module tb_gate_exerciser;
  import gate_exerciser_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_exerciser_if #(.N_IN(2)) if0 ();
  gate_exerciser_if #(.N_IN(3)) if1 ();

  gate_exerciser #(
    .N_IN        (2),
    .HOLD_CYCLES (4),
    .EXPECTED    (OR2_TT)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  gate_exerciser #(
    .N_IN        (3),
    .HOLD_CYCLES (1),
    .EXPECTED    (8'hFE)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  logic       sel = 1'b0;        // 0: dut0, 1: dut1
  logic       start_drv = 1'b0;
  logic [7:0] resp = 8'h00;      // modelled gate: Q = resp[gate_in]

  assign if0.start    = start_drv & ~sel;
  assign if1.start    = start_drv & sel;
  assign if0.gate_out = resp[{1'b0, if0.gate_in}];
  assign if1.gate_out = resp[if1.gate_in];

  logic [31:0] obs_busy, obs_done, obs_pass, obs_gate_in, obs_err, obs_fail;
  always_comb begin
    obs_busy    = '0;
    obs_done    = '0;
    obs_pass    = '0;
    obs_gate_in = '0;
    obs_err     = '0;
    obs_fail    = '0;
    if (sel) begin
      obs_busy    = 32'(if1.busy);
      obs_done    = 32'(if1.done);
      obs_pass    = 32'(if1.pass);
      obs_gate_in = 32'(if1.gate_in);
      obs_err     = 32'(if1.err_count);
      obs_fail    = 32'(if1.fail_vec);
    end else begin
      obs_busy    = 32'(if0.busy);
      obs_done    = 32'(if0.done);
      obs_pass    = 32'(if0.pass);
      obs_gate_in = 32'(if0.gate_in);
      obs_err     = 32'(if0.err_count);
      obs_fail    = 32'(if0.fail_vec);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One full run on the selected DUT. extra_k >= 0 pulses start again during
  // the run, after edge extra_k (must be ignored).
  task automatic run(input logic s, input logic [7:0] r, input int extra_k);
    int         n_in, hold, combos, total, k, eerr;
    logic [7:0] tt, fexp, mask;
    n_in   = s ? 3 : 2;
    hold   = s ? 1 : 4;
    tt     = s ? 8'hFE : {4'h0, OR2_TT};
    combos = 1 << n_in;
    total  = combos * hold;
    mask   = 8'((1 << combos) - 1);
    fexp   = (r ^ tt) & mask;
    eerr   = $countones(fexp);

    @(negedge clk);
    sel       = s;
    resp      = r;
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    check("start_clears_done", obs_done, 0);
    check("start_clears_err", obs_err, 0);
    k = 0;
    while (obs_done == 0 && k < total + 8) begin
      check("busy_in_run", obs_busy, 1);
      check("gate_in_step", obs_gate_in, 32'(k / hold));
      start_drv = (k == extra_k);
      @(negedge clk);
      k++;
    end
    start_drv = 1'b0;
    check("run_length", k, total);
    check("done", obs_done, 1);
    check("busy_after", obs_busy, 0);
    check("gate_in_after", obs_gate_in, 0);
    check("err_count", obs_err, eerr);
    check("fail_vec", obs_fail, 32'(fexp));
    check("pass", obs_pass, (eerr == 0) ? 1 : 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy0", 32'(if0.busy), 0);
    check("rst_done0", 32'(if0.done), 0);
    check("rst_pass0", 32'(if0.pass), 0);
    check("rst_gate_in0", 32'(if0.gate_in), 0);
    check("rst_err0", 32'(if0.err_count), 0);
    check("rst_fail0", 32'(if0.fail_vec), 0);
    check("rst_busy1", 32'(if1.busy), 0);
    check("rst_done1", 32'(if1.done), 0);

    // rst and start together: rst wins
    start_drv = 1'b1;
    @(negedge clk);
    check("rst_beats_start", 32'(if0.busy), 0);
    rst       = 1'b0;
    start_drv = 1'b0;
    @(negedge clk);
    check("idle_no_start", 32'(if0.busy), 0);

    run(1'b0, 8'h0E, -1);  // OR gate, all match
    run(1'b0, 8'h00, -1);  // stuck at 0
    run(1'b0, 8'h08, -1);  // AND gate

    // Reset mid-run with a partial error count
    @(negedge clk);
    sel       = 1'b0;
    resp      = 8'h00;
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_gate_in", obs_gate_in, 2);
    check("pre_rst_err", obs_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", obs_busy, 0);
    check("mid_rst_done", obs_done, 0);
    check("mid_rst_gate_in", obs_gate_in, 0);
    check("mid_rst_err", obs_err, 0);
    check("mid_rst_fail", obs_fail, 0);

    run(1'b0, 8'h0E, -1);  // full OR pass after reset
    run(1'b0, 8'h0E, 5);   // restart attempt at gate_in=01 ignored
    run(1'b0, 8'h00, -1);
    run(1'b0, 8'h0E, -1);  // start from DONE with errors pending
    run(1'b1, 8'hFE, -1);  // 3-input OR, hold 1

    for (int i = 0; i < 10; i++) begin
      run(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Self-checking stimulus and response stage for the basic-gate designs.
- Drives every input combination onto a gate under test (upstream of its A/B inputs) and samples the gate's Q (downstream of its output).
- Compares each sample against a parameterised truth table and reports errors.
- Replaces hand-written delay sequences with a clocked, on-board-usable sequencer that sits between board switches/LEDs and any gate module.

Parameters:
- N_IN, 2, number of gate inputs; combinations = 2**N_IN; legal range 1..4.
- HOLD_CYCLES, 4, clock cycles each combination is held before sampling; legal range 1..255.
- EXPECTED, 4'b1110, expected Q per combination; bit i is the expected Q when gate_in == i; width 2**N_IN; default is the OR truth table.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- gate_in  output  N_IN  stimulus to gate inputs; bit 0 -> A, bit 1 -> B.
- gate_out  input  1  Q from gate under test.
- busy  output  1  high while the run is in progress.
- done  output  1  high from run completion until the next start or reset.
- pass  output  1  valid when done=1; 1 iff err_count == 0.
- err_count  output  N_IN+1  number of mismatching combinations in the last run.
- fail_vec  output  2**N_IN  bit i set if combination i mismatched.

Behaviour:
- Clock and reset: single clock domain, all registers on rising clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, gate_in=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, hold counter=0, combination index=0.
- State IDLE: start=1 -> RUN. On that edge: index=0, hold=0, err_count=0, fail_vec=0, done=0.
- State RUN:
  - busy=1; gate_in = index (registered).
  - hold counts 0..HOLD_CYCLES-1.
  - On the edge where hold == HOLD_CYCLES-1, gate_out is sampled and compared with EXPECTED[index].
  - On mismatch: err_count += 1 and fail_vec[index] = 1.
  - If index == 2**N_IN-1 -> DONE. Otherwise index += 1 and hold = 0.
- State DONE: busy=0, done=1, pass=(err_count==0), gate_in returns to 0. start=1 -> RUN with the same clearing as from IDLE.
- Timing: start sampled at edge 0 -> busy=1 and gate_in=0 from edge 0 through edge 2**N_IN*HOLD_CYCLES -> done=1 after that edge. Each combination is held exactly HOLD_CYCLES cycles.
- start while in RUN is ignored; no restart and no error.
- Settling: HOLD_CYCLES=1 is legal. The gate is combinational, so Q settles within the same cycle gate_in is presented.
- Index wrap: the index never wraps past 2**N_IN-1. err_count width N_IN+1 holds the maximum value 2**N_IN without overflow.
- rst mid-run: all registers return to reset values on the next edge. No partial result is retained.
- rst and start asserted together: rst wins.
- pass and done are registered outputs with no combinational path from gate_out.

Decomposition:
- Shared include gate_test_defs.vh:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - truth-table constants OR2_TT=4'b1110, AND2_TT=4'b1000, XOR2_TT=4'b0110, NAND2_TT=4'b0111, NOR2_TT=4'b0001.
- One natural sub-module, hold_timer:
  - loadable up-counter with inputs clk, rst, clear, enable;
  - output last, asserted when the count equals HOLD_CYCLES-1.
- The FSM, comparison and result registers stay in gate_exerciser.

Test Plan:
1. Defaults, gate_out driven by an OR of gate_in, start pulsed one cycle:
   - gate_in = 00,01,10,11, each held 4 cycles;
   - done rises after 16 cycles;
   - pass=1, err_count=0, fail_vec=4'b0000.
2. Defaults, gate_out tied to 0 -> err_count=3, fail_vec=4'b1110, pass=0, done=1.
3. Defaults, gate_out driven by AND of gate_in -> err_count=2, fail_vec=4'b0110, pass=0.
4. Reset and start interaction:
   - rst asserted for 1 cycle while gate_in=10 in RUN -> next edge: busy=0, done=0, gate_in=00, err_count=0;
   - a subsequent start gives the full OR pass as in scenario 1.
5. Start handling:
   - start pulsed again at gate_in=01 during RUN -> ignored; total run length remains 16 cycles;
   - start pulsed in DONE after scenario 2 -> done=0 and err_count=0 next edge, new run begins.
6. N_IN=3, HOLD_CYCLES=1, EXPECTED=8'hFE, gate_out driven by a 3-input OR:
   - gate_in steps 000..111 one per cycle;
   - done after 8 cycles, pass=1, err_count=0.
